// File: rtl/ahb_lite_sdram_front.sv
// AHB-Lite slave front end: turns bus transfers into command/write-data FIFO pushes and read-data FIFO pops.
// Latency: writes complete with zero wait states; reads take CMD stall + read-FIFO empty time + 3 wait states.
// Backpressure: HREADYOUT is held low while a needed FIFO is full/empty; only one read is outstanding at a time.
module ahb_lite_sdram_front #(
    parameter logic [31:0] ADDR_MASK = 32'h03FF_FFFF,
    parameter int          CMD_WIDTH = 36
) (
    input  logic                 HCLK,
    input  logic                 HRESETn,
    input  logic                 HSEL,
    input  logic [31:0]          HADDR,
    input  logic [1:0]           HTRANS,
    input  logic [2:0]           HSIZE,
    input  logic                 HWRITE,
    input  logic [31:0]          HWDATA,
    input  logic                 HREADY,
    output logic [31:0]          HRDATA,
    output logic                 HREADYOUT,
    output logic                 HRESP,
    output logic                 CFIFO_WEN,
    output logic [CMD_WIDTH-1:0] CFIFO_WDATA,
    input  logic                 CFIFO_WFULL,
    output logic                 WFIFO_WEN,
    output logic [31:0]          WFIFO_WDATA,
    input  logic                 WFIFO_WFULL,
    output logic                 RFIFO_REN,
    input  logic [31:0]          RFIFO_RDATA,
    input  logic                 RFIFO_REMPTY
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_WR,
        S_RD_CMD,
        S_RD_WAIT,
        S_RD_DATA,
        S_RD_DONE
    } state_t;

    state_t      state;
    logic [31:0] addr_q;
    logic [2:0]  size_q;
    logic        write_q;

    logic accept;
    logic wr_go;
    logic take_next;

    // Only NONSEQ/SEQ matter, so HTRANS[0] is deliberately ignored.
    logic unused_htrans0;
    assign unused_htrans0 = HTRANS[0];

    assign accept = HSEL & HREADY & HTRANS[1];
    // A write only moves when both FIFOs can take their half in the same cycle.
    assign wr_go  = ~CFIFO_WFULL & ~WFIFO_WFULL;

    // States in which the current data phase ends this cycle, so a new address phase may be sampled.
    assign take_next = (state == S_IDLE) | ((state == S_WR) & wr_go) | (state == S_RD_DONE);

    // Transfer sequencing, address-phase capture and read data register.
    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            state   <= S_IDLE;
            addr_q  <= '0;
            size_q  <= '0;
            write_q <= 1'b0;
            HRDATA  <= '0;
        end else if (take_next) begin
            if (accept) begin
                addr_q  <= HADDR & ADDR_MASK;
                size_q  <= HSIZE;
                write_q <= HWRITE;
                state   <= HWRITE ? S_WR : S_RD_CMD;
            end else begin
                state <= S_IDLE;
            end
        end else begin
            case (state)
                S_WR:      state <= S_WR;
                S_RD_CMD:  if (!CFIFO_WFULL)  state <= S_RD_WAIT;
                S_RD_WAIT: if (!RFIFO_REMPTY) state <= S_RD_DATA;
                S_RD_DATA: begin
                    HRDATA <= RFIFO_RDATA;
                    state  <= S_RD_DONE;
                end
                default:   state <= S_IDLE;
            endcase
        end
    end

    // Bus ready and FIFO strobes decoded from the state and the live FIFO flags.
    always_comb begin
        HREADYOUT = 1'b1;
        CFIFO_WEN = 1'b0;
        WFIFO_WEN = 1'b0;
        RFIFO_REN = 1'b0;
        case (state)
            S_WR: begin
                HREADYOUT = wr_go;
                CFIFO_WEN = wr_go;
                WFIFO_WEN = wr_go;
            end
            S_RD_CMD: begin
                HREADYOUT = 1'b0;
                CFIFO_WEN = ~CFIFO_WFULL;
            end
            S_RD_WAIT: begin
                HREADYOUT = 1'b0;
                RFIFO_REN = ~RFIFO_REMPTY;
            end
            S_RD_DATA: HREADYOUT = 1'b0;
            default:   HREADYOUT = 1'b1;
        endcase
    end

    // Data is forwarded unshifted; the controller derives byte masks from ADDR[1:0] and SIZE.
    assign CFIFO_WDATA = {write_q, size_q, addr_q};
    assign WFIFO_WDATA = HWDATA;
    assign HRESP       = 1'b0;

endmodule

// File: tb/tb_ahb_lite_sdram_front.sv
// Bench for ahb_lite_sdram_front: AHB master, FIFO models and a transfer-level scoreboard.
// Directed cases from the block's behaviour list, then randomized transfers with random FIFO stalls.
// Outputs are sampled on the falling edge; inputs change 1 ns after the rising edge.
module tb_ahb_lite_sdram_front;

    localparam logic [31:0] ADDR_MASK = 32'h03FF_FFFF;

    logic        HCLK = 1'b0;
    logic        HRESETn;
    logic        HSEL;
    logic [31:0] HADDR;
    logic [1:0]  HTRANS;
    logic [2:0]  HSIZE;
    logic        HWRITE;
    logic [31:0] HWDATA;
    logic        HREADY;
    logic [31:0] HRDATA;
    logic        HREADYOUT;
    logic        HRESP;
    logic        CFIFO_WEN;
    logic [35:0] CFIFO_WDATA;
    logic        CFIFO_WFULL;
    logic        WFIFO_WEN;
    logic [31:0] WFIFO_WDATA;
    logic        WFIFO_WFULL;
    logic        RFIFO_REN;
    logic [31:0] RFIFO_RDATA;
    logic        RFIFO_REMPTY;

    always #5 HCLK = ~HCLK;

    // Single slave on the bus: the bus-wide ready is this slave's ready.
    assign HREADY = HREADYOUT;

    ahb_lite_sdram_front #(.ADDR_MASK(ADDR_MASK), .CMD_WIDTH(36)) dut (
        .HCLK(HCLK), .HRESETn(HRESETn), .HSEL(HSEL), .HADDR(HADDR), .HTRANS(HTRANS),
        .HSIZE(HSIZE), .HWRITE(HWRITE), .HWDATA(HWDATA), .HREADY(HREADY),
        .HRDATA(HRDATA), .HREADYOUT(HREADYOUT), .HRESP(HRESP),
        .CFIFO_WEN(CFIFO_WEN), .CFIFO_WDATA(CFIFO_WDATA), .CFIFO_WFULL(CFIFO_WFULL),
        .WFIFO_WEN(WFIFO_WEN), .WFIFO_WDATA(WFIFO_WDATA), .WFIFO_WFULL(WFIFO_WFULL),
        .RFIFO_REN(RFIFO_REN), .RFIFO_RDATA(RFIFO_RDATA), .RFIFO_REMPTY(RFIFO_REMPTY)
    );

    typedef struct {
        logic        sel;
        logic [1:0]  trans;
        logic        write;
        logic [2:0]  size;
        logic [31:0] addr;
        logic [31:0] wdata;
    } xfer_t;

    int total = 0;
    int bad   = 0;

    xfer_t       req_q[$];
    logic [35:0] exp_cmd_q[$];
    logic [31:0] exp_wd_q[$];
    logic [31:0] rf_q[$];

    xfer_t       dp;
    bit          dp_vld;
    int          cyc;
    int          cfull_pct, wfull_pct, cfull_hold, next_rd_delay;
    bit          use_rd_data;
    logic [31:0] next_rd_data;
    bit          resp_vld;
    logic [31:0] resp_data;
    int          resp_ready;
    bit          ren_pending;
    logic [31:0] ren_data;
    logic [31:0] rd_exp, last_rd_val;
    int          rd_phase, cmd_stall, empty_time, dp_wait, ren_cnt, ren_cyc;
    int          last_dp_wait, last_wr_push, last_rd_push;
    logic [35:0] last_cmd;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    task automatic add_xfer(input logic sel, input logic [1:0] trans, input logic write,
                            input logic [2:0] size, input logic [31:0] addr, input logic [31:0] wdata);
        xfer_t t;
        t.sel = sel; t.trans = trans; t.write = write;
        t.size = size; t.addr = addr; t.wdata = wdata;
        req_q.push_back(t);
    endtask

    // Everything observed during one bus cycle, judged against transfer-level expectations.
    task automatic observe();
        logic [35:0] ec;
        logic        ready;
        xfer_t       t;
        ready = HREADYOUT;
        chk("hresp", HRESP, 0);
        chk("cwen_while_full", CFIFO_WEN & CFIFO_WFULL, 0);
        chk("wwen_while_full", WFIFO_WEN & WFIFO_WFULL, 0);
        chk("ren_while_empty", RFIFO_REN & RFIFO_REMPTY, 0);

        if (CFIFO_WEN) begin
            if (exp_cmd_q.size() == 0) begin
                chk("cmd_spurious", CFIFO_WEN, 0);
            end else begin
                ec = exp_cmd_q.pop_front();
                chk("cmd_word", CFIFO_WDATA, ec);
                chk("wfifo_paired", WFIFO_WEN, ec[35]);
                last_cmd = CFIFO_WDATA;
                if (ec[35]) begin
                    last_wr_push = cyc;
                    if (exp_wd_q.size() > 0) chk("wfifo_data", WFIFO_WDATA, exp_wd_q.pop_front());
                end else begin
                    last_rd_push = cyc;
                    resp_data  = use_rd_data ? next_rd_data : $urandom();
                    resp_ready = cyc + 1 + ((next_rd_delay >= 0) ? next_rd_delay : int'($urandom_range(6)));
                    resp_vld   = 1;
                    rd_exp     = resp_data;
                end
            end
        end else begin
            chk("wfifo_alone", WFIFO_WEN, 0);
        end

        if (RFIFO_REN && rf_q.size() > 0) begin
            ren_data    = rf_q.pop_front();
            ren_pending = 1;
        end

        if (dp_vld) begin
            if (dp.write) begin
                chk("wr_ready", ready, !CFIFO_WFULL && !WFIFO_WFULL);
                chk("ren_in_write", RFIFO_REN, 0);
            end else begin
                if (RFIFO_REN) begin
                    ren_cnt++;
                    ren_cyc = cyc;
                end
                if (rd_phase == 0) begin
                    if (CFIFO_WFULL) cmd_stall++; else rd_phase = 1;
                end else if (rd_phase == 1) begin
                    if (RFIFO_REMPTY) empty_time++; else rd_phase = 2;
                end
                if (ready) begin
                    chk("rd_data", HRDATA, rd_exp);
                    chk("rd_wait", dp_wait, cmd_stall + empty_time + 3);
                    chk("rd_ren_count", ren_cnt, 1);
                    chk("rd_ren_to_done", cyc - ren_cyc, 2);
                    last_rd_val = rd_exp;
                end
            end
            if (ready) begin
                last_dp_wait = dp_wait;
                dp_vld = 0;
            end else begin
                dp_wait++;
            end
        end else begin
            chk("idle_ready", ready, 1);
            chk("idle_ren", RFIFO_REN, 0);
        end

        if (!(dp_vld && !dp.write)) chk("hrdata_hold", HRDATA, last_rd_val);

        if (ready && req_q.size() > 0) begin
            t = req_q.pop_front();
            if (t.sel && t.trans[1]) begin
                dp = t; dp_vld = 1; dp_wait = 0;
                rd_phase = 0; cmd_stall = 0; empty_time = 0; ren_cnt = 0; ren_cyc = -100;
                exp_cmd_q.push_back({t.write, t.size, t.addr & ADDR_MASK});
                if (t.write) exp_wd_q.push_back(t.wdata);
            end
        end
    endtask

    // One bus cycle: drive master and FIFO-side inputs, then observe on the falling edge.
    task automatic tick();
        @(posedge HCLK);
        #1;
        cyc++;
        if (ren_pending) begin
            RFIFO_RDATA = ren_data;
            ren_pending = 0;
        end
        if (resp_vld && cyc >= resp_ready) begin
            rf_q.push_back(resp_data);
            resp_vld = 0;
        end
        RFIFO_REMPTY = (rf_q.size() == 0);
        if (cfull_hold > 0) begin
            CFIFO_WFULL = 1'b1;
            cfull_hold--;
        end else begin
            CFIFO_WFULL = ($urandom_range(99) < cfull_pct);
        end
        WFIFO_WFULL = ($urandom_range(99) < wfull_pct);
        if (req_q.size() > 0) begin
            HSEL = req_q[0].sel; HTRANS = req_q[0].trans; HADDR = req_q[0].addr;
            HSIZE = req_q[0].size; HWRITE = req_q[0].write;
        end else begin
            HSEL = 1'b0; HTRANS = 2'($urandom_range(3)); HADDR = $urandom();
            HSIZE = 3'd0; HWRITE = 1'($urandom_range(1));
        end
        HWDATA = (dp_vld && dp.write) ? dp.wdata : $urandom();
        @(negedge HCLK);
        observe();
    endtask

    task automatic drain(input int max_cycles);
        int n;
        n = 0;
        while ((req_q.size() > 0 || dp_vld) && n < max_cycles) begin
            tick();
            n++;
        end
        chk("drain_timeout", (req_q.size() > 0 || dp_vld), 0);
        chk("cmd_outstanding", exp_cmd_q.size(), 0);
    endtask

    initial begin
        bit found;
        cyc = 0; dp_vld = 0; resp_vld = 0; ren_pending = 0;
        cfull_pct = 0; wfull_pct = 0; cfull_hold = 0; next_rd_delay = -1; use_rd_data = 0;
        last_rd_val = '0; rd_exp = '0; last_cmd = '0; next_rd_data = '0;
        HRESETn = 1'b0; HSEL = 1'b1; HTRANS = 2'b10; HADDR = 32'h0; HSIZE = 3'd2;
        HWRITE = 1'b1; HWDATA = 32'h0; CFIFO_WFULL = 1'b0; WFIFO_WFULL = 1'b0;
        RFIFO_RDATA = 32'h0; RFIFO_REMPTY = 1'b0;

        // Reset state.
        repeat (3) @(posedge HCLK);
        @(negedge HCLK);
        chk("rst_hreadyout", HREADYOUT, 1);
        chk("rst_hrdata", HRDATA, 0);
        chk("rst_cfifo_wen", CFIFO_WEN, 0);
        chk("rst_wfifo_wen", WFIFO_WEN, 0);
        chk("rst_rfifo_ren", RFIFO_REN, 0);
        chk("rst_cmd_word", CFIFO_WDATA, 0);
        HSEL = 1'b0; RFIFO_REMPTY = 1'b1;
        #2 HRESETn = 1'b1;

        // Word write, FIFOs empty: zero wait.
        add_xfer(1, 2'b10, 1, 3'b010, 32'h0000_1234, 32'hDEAD_BEEF);
        drain(50);
        chk("t1_cmd", last_cmd, 36'hA_0000_1234);
        chk("t1_wait", last_dp_wait, 0);

        // Byte read, data arrives after 5 empty cycles.
        next_rd_delay = 5; use_rd_data = 1; next_rd_data = 32'h1122_3344;
        add_xfer(1, 2'b10, 0, 3'b000, 32'h4000_0101, 32'h0);
        drain(50);
        chk("t2_cmd", last_cmd, 36'h0_0000_0101);
        chk("t2_hrdata", HRDATA, 32'h1122_3344);
        chk("t2_wait", last_dp_wait, 8);
        next_rd_delay = -1; use_rd_data = 0;

        // Write with the command FIFO full for the first 3 data-phase cycles.
        add_xfer(1, 2'b10, 1, 3'b010, 32'h0000_0020, 32'hCAFE_F00D);
        tick();
        cfull_hold = 3;
        drain(50);
        chk("t3_wait", last_dp_wait, 3);
        chk("t3_hrdata_kept", HRDATA, 32'h1122_3344);

        // Pipelined write then read: read command pushed the cycle after the write push.
        next_rd_delay = 0;
        add_xfer(1, 2'b10, 1, 3'b010, 32'h0000_0010, 32'h0BAD_F00D);
        add_xfer(1, 2'b11, 0, 3'b010, 32'h0000_0014, 32'h0);
        drain(50);
        chk("t4_gap", last_rd_push - last_wr_push, 1);
        chk("t4_cmd", last_cmd, 36'h2_0000_0014);
        next_rd_delay = -1;

        // IDLE / BUSY with HSEL=1 and a deselected NONSEQ: no FIFO activity.
        add_xfer(1, 2'b00, 1, 3'b010, 32'h0000_0040, 32'h0);
        add_xfer(1, 2'b01, 0, 3'b010, 32'h0000_0044, 32'h0);
        add_xfer(0, 2'b10, 1, 3'b010, 32'h0000_0048, 32'h0);
        drain(50);

        // Randomized traffic with random FIFO stalls.
        cfull_pct = 25; wfull_pct = 25;
        for (int i = 0; i < 300; i++) begin
            add_xfer(($urandom_range(9) != 0), 2'($urandom_range(3)), 1'($urandom_range(1)),
                     3'($urandom_range(2)), $urandom(), $urandom());
        end
        drain(6000);
        cfull_pct = 0; wfull_pct = 0;

        // Reset asserted while the read is waiting on the read FIFO.
        next_rd_delay = 0;
        add_xfer(1, 2'b10, 0, 3'b010, 32'h0000_0200, 32'h0);
        found = 0;
        for (int i = 0; i < 20 && !found; i++) begin
            tick();
            if (RFIFO_REN) found = 1;
        end
        chk("t6_reached_wait", found, 1);
        #2 HRESETn = 1'b0;
        #1;
        chk("t6_async_hreadyout", HREADYOUT, 1);
        chk("t6_async_ren", RFIFO_REN, 0);
        chk("t6_async_cwen", CFIFO_WEN, 0);
        chk("t6_async_wwen", WFIFO_WEN, 0);
        chk("t6_async_hrdata", HRDATA, 0);
        req_q.delete(); exp_cmd_q.delete(); exp_wd_q.delete(); rf_q.delete();
        dp_vld = 0; resp_vld = 0; ren_pending = 0; last_rd_val = '0;
        HSEL = 1'b0; RFIFO_REMPTY = 1'b1;
        @(posedge HCLK);
        #1;
        chk("t6_held_hreadyout", HREADYOUT, 1);
        HRESETn = 1'b1;
        next_rd_delay = -1;

        // New write after reset release.
        add_xfer(1, 2'b10, 1, 3'b001, 32'h8000_0008, 32'h55AA_1234);
        drain(50);
        chk("t7_cmd", last_cmd, 36'h9_0000_0008);
        chk("t7_wait", last_dp_wait, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
